// File: rtl/debounce_edge.sv
// Synchronizing debouncer with registered rise/fall/glitch pulses.
// A new level is accepted only after it has held for DEBOUNCE_CYCLES synchronized edges.
module debounce_edge #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter logic INIT_LEVEL      = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall,
  output logic glitch
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    IDLE,
    PENDING
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sync_q;
  logic [CW-1:0]          cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_chain <= {SYNC_STAGES{INIT_LEVEL}};
    end else begin
      sync_chain[0] <= in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_chain[i] <= sync_chain[i-1];
      end
    end
  end

  assign sync_q = sync_chain[SYNC_STAGES-1];

  // PENDING tracks cnt != 0; acceptance wins over counting once the hold time is met.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      out    <= INIT_LEVEL;
      rise   <= 1'b0;
      fall   <= 1'b0;
      glitch <= 1'b0;
    end else begin
      rise   <= 1'b0;
      fall   <= 1'b0;
      glitch <= 1'b0;
      if (sync_q != out) begin
        if (cnt == CNT_LAST) begin
          out   <= sync_q;
          cnt   <= '0;
          rise  <= sync_q;
          fall  <= ~sync_q;
          state <= IDLE;
        end else begin
          cnt   <= cnt + CW'(1);
          state <= PENDING;
        end
      end else if (state == PENDING) begin
        cnt    <= '0;
        glitch <= 1'b1;
        state  <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_debounce_edge.sv
// Scoreboard bench for debounce_edge: stimulus queues expected pulses with their edge index,
// a negedge monitor pops and compares whenever a pulse appears or an expected one is overdue.
module tb_debounce_edge;

  localparam int K_RISE   = 0;
  localparam int K_FALL   = 1;
  localparam int K_GLITCH = 2;

  typedef struct {
    int   kind;
    int   cyc;
    logic outv;
  } evt_t;

  logic clk = 1'b0;
  logic rst;
  logic in0, out0, rise0, fall0, glitch0;
  logic in1, out1, rise1, fall1, glitch1;

  int   edgeIdx    = 0;
  int   checkCount = 0;
  int   passCount  = 0;
  int   maxCnt     = 0;
  evt_t expQ0[$];
  evt_t expQ1[$];

  debounce_edge #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .INIT_LEVEL(1'b0)) dut (
    .clk(clk), .rst(rst), .in(in0),
    .out(out0), .rise(rise0), .fall(fall0), .glitch(glitch0)
  );

  debounce_edge #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .INIT_LEVEL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in(in1),
    .out(out1), .rise(rise1), .fall(fall1), .glitch(glitch1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edgeIdx <= edgeIdx + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, edgeIdx);
  endtask

  task automatic pushExp(input int id, input int kind, input int cyc, input logic outv);
    evt_t e;
    e.kind = kind;
    e.cyc  = cyc;
    e.outv = outv;
    if (id == 0) expQ0.push_back(e);
    else         expQ1.push_back(e);
  endtask

  // Drives one instance's input at a negedge; base is the edge count before "edge 0".
  task automatic applyStimulus(input int id, input logic v, output int base);
    @(negedge clk);
    if (id == 0) in0 = v;
    else         in1 = v;
    base = edgeIdx;
  endtask

  task automatic scoreInst(input int id, input logic r, input logic f, input logic g, input logic o);
    evt_t e;
    bit   have;
    int   kind;
    have = (id == 0) ? (expQ0.size() > 0) : (expQ1.size() > 0);
    if (have) e = (id == 0) ? expQ0[0] : expQ1[0];
    if (r || f || g) begin
      kind = r ? K_RISE : (f ? K_FALL : K_GLITCH);
      checkOutput($sformatf("pulse exclusive dut%0d", id), int'(r) + int'(f) + int'(g), 1);
      if (!have) begin
        checkCount++;
        $display("[TB] FAIL unexpected pulse dut%0d: kind %0d at edge %0d, none expected", id, kind, edgeIdx);
      end else begin
        if (id == 0) void'(expQ0.pop_front());
        else         void'(expQ1.pop_front());
        checkOutput($sformatf("pulse kind dut%0d", id), kind, e.kind);
        checkOutput($sformatf("pulse edge dut%0d", id), edgeIdx, e.cyc);
        checkOutput($sformatf("out with pulse dut%0d", id), int'(o), int'(e.outv));
      end
    end else if (have && e.cyc <= edgeIdx) begin
      if (id == 0) void'(expQ0.pop_front());
      else         void'(expQ1.pop_front());
      checkCount++;
      $display("[TB] FAIL missed pulse dut%0d: kind %0d absent at edge %0d, expected at edge %0d", id, e.kind, edgeIdx, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      scoreInst(0, rise0, fall0, glitch0, out0);
      scoreInst(1, rise1, fall1, glitch1, out1);
      if (int'(dut.cnt) > maxCnt) maxCnt = int'(dut.cnt);
    end
  end

  initial begin
    int base;
    rst = 1'b1;
    in0 = 1'b0;
    in1 = 1'b1;
    #3;
    checkOutput("reset out0", int'(out0), 0);
    checkOutput("reset pulses0", int'({rise0, fall0, glitch0}), 0);
    checkOutput("reset out1", int'(out1), 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Scenario 1: clean rise
    applyStimulus(0, 1'b1, base);
    pushExp(0, K_RISE, base + 6, 1'b1);
    repeat (5) @(negedge clk);
    checkOutput("s1 out after edge 4", int'(out0), 0);
    @(negedge clk);
    checkOutput("s1 out after edge 5", int'(out0), 1);
    repeat (4) @(negedge clk);
    applyStimulus(0, 1'b0, base);
    pushExp(0, K_FALL, base + 6, 1'b0);
    repeat (10) @(negedge clk);
    checkOutput("s1 out back low", int'(out0), 0);

    // Scenario 2: three sampled edges high -> glitch
    applyStimulus(0, 1'b1, base);
    pushExp(0, K_GLITCH, base + 6, 1'b0);
    repeat (3) @(negedge clk);
    in0 = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("s2 out stays low", int'(out0), 0);

    // Scenario 3: four sampled edges high -> rise then fall
    applyStimulus(0, 1'b1, base);
    pushExp(0, K_RISE, base + 6, 1'b1);
    pushExp(0, K_FALL, base + 10, 1'b0);
    repeat (4) @(negedge clk);
    in0 = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("s3 out high", int'(out0), 1);
    repeat (10) @(negedge clk);

    // Scenario 4: toggle every 2 cycles for 40 cycles -> glitches only
    applyStimulus(0, 1'b1, base);
    for (int j = 0; j < 10; j++) pushExp(0, K_GLITCH, base + 4 * j + 5, 1'b0);
    for (int t = 1; t < 20; t++) begin
      repeat (2) @(negedge clk);
      in0 = ~in0;
    end
    repeat (12) @(negedge clk);
    checkOutput("s4 out constant", int'(out0), 0);
    checkOutput("s4 cnt bounded", int'(maxCnt <= 3), 1);

    // Scenario 5: async reset mid-PENDING
    applyStimulus(0, 1'b1, base);
    repeat (4) @(negedge clk);
    checkOutput("s5 cnt pending", int'(dut.cnt), 2);
    #2 rst = 1'b1;
    #1;
    checkOutput("s5 cnt cleared", int'(dut.cnt), 0);
    checkOutput("s5 out cleared", int'(out0), 0);
    checkOutput("s5 pulses cleared", int'({rise0, fall0, glitch0}), 0);
    in0 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Async reset while out is high clears out at once
    applyStimulus(0, 1'b1, base);
    pushExp(0, K_RISE, base + 6, 1'b1);
    repeat (8) @(negedge clk);
    checkOutput("s5b out high", int'(out0), 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("s5b out cleared", int'(out0), 0);
    in0 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // Scenario 6: DEBOUNCE_CYCLES=1, INIT_LEVEL=1
    checkOutput("s6 out init", int'(out1), 1);
    applyStimulus(1, 1'b0, base);
    pushExp(1, K_FALL, base + 3, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("s6 out after edge 1", int'(out1), 1);
    @(negedge clk);
    checkOutput("s6 out after edge 2", int'(out1), 0);
    repeat (6) @(negedge clk);

    checkOutput("queue0 drained", expQ0.size(), 0);
    checkOutput("queue1 drained", expQ1.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
